id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Parametrised ID/EX pipeline register for the RV32 integer/float core. It sits between decode and execute and captures the decoded instruction: PC, immediate, an opaque control bundle, destination, and up to NUM_SRC source operands. It supports stall (hold), flush (bubble insertion) and a valid bit. Operand forwarding takes two sources with fixed priority: the MEM result, then the WB result. Held operands are refreshed from WB while the stage is stalled, so a stalled instruction never keeps a stale operand.

## Interface
- XLEN, 32, datapath width
- REG_AW, 6, register address width; bit 5 set selects the float file, 6'd0 is integer x0
- NUM_SRC, 3, number of source operands (2 = integer/FALU, 3 = fused multiply-add)
- CTRL_W, 16, width of the opaque decoded-control bundle
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  decode stage holds a real instruction
- id_pc  in  XLEN  PC of the decoded instruction
- id_imm  in  XLEN  sign-extended immediate
- id_ctrl  in  CTRL_W  decoded control bundle
- id_rd  in  REG_AW  destination address
- id_rs_addr  in  NUM_SRC*REG_AW  source addresses; operand i is at bits [i*REG_AW +: REG_AW]
- id_rs_data  in  NUM_SRC*XLEN  register-file read data, already taken from the integer or float file by the decoder
- stall  in  1  hold the stage contents
- flush  in  1  kill the instruction entering or held in the stage
- mem_fwd_en, mem_fwd_rd, mem_fwd_data  in  1/REG_AW/XLEN  MEM-stage pending write
- wb_fwd_en, wb_fwd_rd, wb_fwd_data  in  1/REG_AW/XLEN  WB-stage register write this cycle
- ex_valid  out  1  EX holds a real instruction
- ex_pc, ex_imm, ex_ctrl, ex_rd  out  XLEN/XLEN/CTRL_W/REG_AW  registered copies of the ID fields
- ex_rs_addr  out  NUM_SRC*REG_AW  registered source addresses
- ex_rs_data  out  NUM_SRC*XLEN  registered, forwarded operands
- ex_fwd_src  out  NUM_SRC*2  per operand: 00 register file, 01 WB, 10 MEM, 11 refreshed during stall

## Operation
- Match rule: source `src` matches forward port P when P_en=1, P_rd==src and src!=6'd0.
  - Float address 6'd32 (f0) is a real register and is forwarded.
  - The comparison uses all REG_AW bits, so integer and float registers never alias.
- Operand select at capture: MEM match, else WB match, else id_rs_data[i]. ex_fwd_src is set to 10, 01 or 00 to match.
- Each cycle, one of three actions applies, with priority flush > stall > load.
  - Flush (flush=1, stall don't-care): ex_valid←0, ex_ctrl←0, ex_rd←0. ex_pc, ex_imm, ex_rs_addr, ex_rs_data and ex_fwd_src hold.
  - Stall (stall=1, flush=0): all fields hold. Exception: for each operand i whose ex_rs_addr[i] matches the WB port, ex_rs_data[i]←wb_fwd_data and ex_fwd_src[i]←11. The MEM port is ignored during stall; its value reaches WB in a later cycle and is caught then.
  - Load (stall=0, flush=0): ex_valid←id_valid and every field takes its ID value or its forwarded value. A load with id_valid=0 still loads the fields; downstream must qualify on ex_valid.
- Operand refresh on stall applies even when ex_valid=0. This is harmless.
- NUM_SRC=2: no third-operand logic exists; ex_fwd_src is 4 bits wide.

## Timing
- Latency: ID inputs appear on EX outputs one clk edge after capture. There is no combinational path from inputs to outputs.
- The forward ports are sampled at the same edge as the ID inputs. Data that WB writes in cycle N is forwarded into the value captured at the end of cycle N.
- Reset (rst_n=0, asynchronous): every output goes to 0, including ex_valid, ex_ctrl, ex_rd and ex_fwd_src. Release is synchronous to the next edge. Reset asserted mid-stall discards the held instruction.
- Simultaneous flush and stall: flush wins, and the stage holds a bubble on the next cycle.
- Simultaneous MEM and WB match on the same source: MEM wins at load.
- Duplicate sources (rs1==rs2): each operand is forwarded independently and identically.
- A stall lasting many cycles refreshes again on every WB match. The last write wins.

## Test plan
- Reset: rst_n=0 with random inputs → all outputs 0. After release, id_valid=1, id_pc=0x100, no stall/flush → next edge ex_valid=1, ex_pc=0x100.
- Priority: id_rs_addr[0]=5, mem_fwd_rd=5 with data 0xAAAA, wb_fwd_rd=5 with data 0xBBBB, id_rs_data[0]=0x1111 → ex_rs_data[0]=0xAAAA, ex_fwd_src[0]=10. Repeat with mem_fwd_en=0 → 0xBBBB, 01.
- x0 and file separation: source 6'd0 with mem_fwd_rd=0, en=1 → register-file value, src 00. Source 6'd37 with wb_fwd_rd=6'd5 → no forward. Source 6'd32 with wb_fwd_rd=6'd32 → forwarded.
- Stall refresh: load rs2=9 with data 0x10, stall for 3 cycles, WB writes r9=0x20 in cycle 2 → ex_rs_data[1]=0x20, src=11; all other fields unchanged throughout.
- Flush and stall together: a valid instruction is held, then flush=1 and stall=1 in the same cycle → ex_valid=0, ex_ctrl=0, ex_rd=0, ex_pc unchanged.
- Back-to-back: 8 consecutive valid loads with incrementing PCs and no stalls → ex_pc follows id_pc exactly one cycle later, with no gaps.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register.
// Captures the decoded instruction and its source operands, with MEM/WB
// operand forwarding at capture time and WB refresh of held operands
// while the stage is stalled. Priority each cycle: flush > stall > load.
module id_ex_stage #(
    parameter int XLEN    = 32,
    parameter int REG_AW  = 6,
    parameter int NUM_SRC = 3,
    parameter int CTRL_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_valid,
    input  logic [XLEN-1:0]           id_pc,
    input  logic [XLEN-1:0]           id_imm,
    input  logic [CTRL_W-1:0]         id_ctrl,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs_addr,
    input  logic [NUM_SRC*XLEN-1:0]   id_rs_data,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      mem_fwd_en,
    input  logic [REG_AW-1:0]         mem_fwd_rd,
    input  logic [XLEN-1:0]           mem_fwd_data,
    input  logic                      wb_fwd_en,
    input  logic [REG_AW-1:0]         wb_fwd_rd,
    input  logic [XLEN-1:0]           wb_fwd_data,
    output logic                      ex_valid,
    output logic [XLEN-1:0]           ex_pc,
    output logic [XLEN-1:0]           ex_imm,
    output logic [CTRL_W-1:0]         ex_ctrl,
    output logic [REG_AW-1:0]         ex_rd,
    output logic [NUM_SRC*REG_AW-1:0] ex_rs_addr,
    output logic [NUM_SRC*XLEN-1:0]   ex_rs_data,
    output logic [NUM_SRC*2-1:0]      ex_fwd_src
);

    // Operand origin codes reported on ex_fwd_src.
    localparam logic [1:0] SRC_RF    = 2'b00;
    localparam logic [1:0] SRC_WB    = 2'b01;
    localparam logic [1:0] SRC_MEM   = 2'b10;
    localparam logic [1:0] SRC_STALL = 2'b11;

    // Per-operand views of the flat source buses.
    logic [NUM_SRC-1:0][REG_AW-1:0] src_addr;
    logic [NUM_SRC-1:0][XLEN-1:0]   src_data;

    assign src_addr = id_rs_addr;
    assign src_data = id_rs_data;

    // Stage state.
    logic                           valid_q;
    logic [XLEN-1:0]                pc_q;
    logic [XLEN-1:0]                imm_q;
    logic [CTRL_W-1:0]              ctrl_q;
    logic [REG_AW-1:0]              rd_q;
    logic [NUM_SRC-1:0][REG_AW-1:0] rs_addr_q;
    logic [NUM_SRC-1:0][XLEN-1:0]   rs_data_q;
    logic [NUM_SRC-1:0][1:0]        fwd_src_q;

    // Forwarding candidates.
    logic [NUM_SRC-1:0][XLEN-1:0]   load_data;
    logic [NUM_SRC-1:0][1:0]        load_src;
    logic [NUM_SRC-1:0]             refresh_hit;

    // A write port matches a source only when enabled, on the full address
    // (so integer and float files never alias) and never for integer x0.
    // f0 (6'd32) is a real register and does match.
    function automatic logic fwd_match(input logic              en,
                                       input logic [REG_AW-1:0] port_rd,
                                       input logic [REG_AW-1:0] src);
        return en && (port_rd == src) && (src != '0);
    endfunction

    // Select each operand's capture value (MEM over WB over register file)
    // and detect WB hits on the held operands for stall refresh.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            // NOTE: every output of this block gets a default before any
            // condition, so no path leaves it unassigned and no latch forms.
            load_data[i]   = src_data[i];
            load_src[i]    = SRC_RF;
            refresh_hit[i] = fwd_match(wb_fwd_en, wb_fwd_rd, rs_addr_q[i]);
            if (fwd_match(mem_fwd_en, mem_fwd_rd, src_addr[i])) begin
                load_data[i] = mem_fwd_data;
                load_src[i]  = SRC_MEM;
            end else if (fwd_match(wb_fwd_en, wb_fwd_rd, src_addr[i])) begin
                load_data[i] = wb_fwd_data;
                load_src[i]  = SRC_WB;
            end
        end
    end

    // Stage register: flush inserts a bubble, stall holds (refreshing
    // operands from WB), otherwise capture the decoded instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            valid_q   <= 1'b0;
            pc_q      <= '0;
            imm_q     <= '0;
            ctrl_q    <= '0;
            rd_q      <= '0;
            rs_addr_q <= '0;
            rs_data_q <= '0;
            fwd_src_q <= '0;
        end else if (flush) begin
            // Only the fields that make the slot architecturally live are
            // cleared; the datapath fields hold.
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            rd_q    <= '0;
        end else if (stall) begin
            // MEM is ignored here; its value arrives on WB later and is
            // caught then. Refresh applies even to a bubble, harmlessly.
            for (int i = 0; i < NUM_SRC; i++) begin
                if (refresh_hit[i]) begin
                    rs_data_q[i] <= wb_fwd_data;
                    fwd_src_q[i] <= SRC_STALL;
                end
            end
        end else begin
            // Fields load even when id_valid=0; downstream qualifies on valid.
            valid_q   <= id_valid;
            pc_q      <= id_pc;
            imm_q     <= id_imm;
            ctrl_q    <= id_ctrl;
            rd_q      <= id_rd;
            rs_addr_q <= src_addr;
            rs_data_q <= load_data;
            fwd_src_q <= load_src;
        end
    end

    assign ex_valid   = valid_q;
    assign ex_pc      = pc_q;
    assign ex_imm     = imm_q;
    assign ex_ctrl    = ctrl_q;
    assign ex_rd      = rd_q;
    assign ex_rs_addr = rs_addr_q;
    assign ex_rs_data = rs_data_q;
    assign ex_fwd_src = fwd_src_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: scoreboard of expected stage contents pushed
// each cycle, compared after the edge, plus scenario-specific checks.
module tb_id_ex_stage;

    localparam int XLEN    = 32;
    localparam int REG_AW  = 6;
    localparam int NUM_SRC = 3;
    localparam int CTRL_W  = 16;

    typedef struct packed {
        logic                           valid;
        logic [XLEN-1:0]                pc;
        logic [XLEN-1:0]                imm;
        logic [CTRL_W-1:0]              ctrl;
        logic [REG_AW-1:0]              rd;
        logic [NUM_SRC-1:0][REG_AW-1:0] rs_addr;
        logic [NUM_SRC-1:0][XLEN-1:0]   rs_data;
        logic [NUM_SRC-1:0][1:0]        fwd_src;
    } exp_t;

    logic                           clk = 1'b0;
    logic                           rst_n = 1'b0;
    logic                           id_valid = 1'b0;
    logic [XLEN-1:0]                id_pc = '0;
    logic [XLEN-1:0]                id_imm = '0;
    logic [CTRL_W-1:0]              id_ctrl = '0;
    logic [REG_AW-1:0]              id_rd = '0;
    logic [NUM_SRC-1:0][REG_AW-1:0] id_rs_addr = '0;
    logic [NUM_SRC-1:0][XLEN-1:0]   id_rs_data = '0;
    logic                           stall = 1'b0;
    logic                           flush = 1'b0;
    logic                           mem_fwd_en = 1'b0;
    logic [REG_AW-1:0]              mem_fwd_rd = '0;
    logic [XLEN-1:0]                mem_fwd_data = '0;
    logic                           wb_fwd_en = 1'b0;
    logic [REG_AW-1:0]              wb_fwd_rd = '0;
    logic [XLEN-1:0]                wb_fwd_data = '0;

    logic                           ex_valid;
    logic [XLEN-1:0]                ex_pc;
    logic [XLEN-1:0]                ex_imm;
    logic [CTRL_W-1:0]              ex_ctrl;
    logic [REG_AW-1:0]              ex_rd;
    logic [NUM_SRC-1:0][REG_AW-1:0] ex_rs_addr;
    logic [NUM_SRC-1:0][XLEN-1:0]   ex_rs_data;
    logic [NUM_SRC-1:0][1:0]        ex_fwd_src;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t model = '0;
    exp_t sb_q[$];
    exp_t mon_e;

    id_ex_stage #(
        .XLEN(XLEN), .REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .CTRL_W(CTRL_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .id_rd(id_rd), .id_rs_addr(id_rs_addr), .id_rs_data(id_rs_data),
        .stall(stall), .flush(flush),
        .mem_fwd_en(mem_fwd_en), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
        .wb_fwd_en(wb_fwd_en), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
        .ex_rd(ex_rd), .ex_rs_addr(ex_rs_addr), .ex_rs_data(ex_rs_data),
        .ex_fwd_src(ex_fwd_src)
    );

    always #5 clk = ~clk;

    function automatic logic hit(input logic en, input logic [REG_AW-1:0] prd,
                                 input logic [REG_AW-1:0] src);
        return en && (prd == src) && (src != 6'd0);
    endfunction

    // Reference behaviour of one clock edge, from the current inputs.
    function automatic exp_t model_next(input exp_t cur);
        exp_t n = cur;
        if (flush) begin
            n.valid = 1'b0;
            n.ctrl  = '0;
            n.rd    = '0;
        end else if (stall) begin
            for (int i = 0; i < NUM_SRC; i++)
                if (hit(wb_fwd_en, wb_fwd_rd, cur.rs_addr[i])) begin
                    n.rs_data[i] = wb_fwd_data;
                    n.fwd_src[i] = 2'b11;
                end
        end else begin
            n.valid   = id_valid;
            n.pc      = id_pc;
            n.imm     = id_imm;
            n.ctrl    = id_ctrl;
            n.rd      = id_rd;
            n.rs_addr = id_rs_addr;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (hit(mem_fwd_en, mem_fwd_rd, id_rs_addr[i])) begin
                    n.rs_data[i] = mem_fwd_data;
                    n.fwd_src[i] = 2'b10;
                end else if (hit(wb_fwd_en, wb_fwd_rd, id_rs_addr[i])) begin
                    n.rs_data[i] = wb_fwd_data;
                    n.fwd_src[i] = 2'b01;
                end else begin
                    n.rs_data[i] = id_rs_data[i];
                    n.fwd_src[i] = 2'b00;
                end
            end
        end
        return n;
    endfunction

    // Push the expected result of the coming edge, then advance past it.
    task automatic tick();
        model = model_next(model);
        sb_q.push_back(model);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        mem_fwd_en = 1'b0; wb_fwd_en = 1'b0;
        id_rs_addr = '0; id_rs_data = '0;
    endtask

    // Scoreboard consumer: compare the full stage contents after each edge.
    always @(posedge clk) begin
        #1;
        if (rst_n && sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            n_vec++;
            if (ex_valid !== mon_e.valid) begin
                n_err++; $display("FAIL sb_valid: got %0h expected %0h", ex_valid, mon_e.valid);
            end
            if (ex_pc !== mon_e.pc || ex_imm !== mon_e.imm) begin
                n_err++; $display("FAIL sb_pc_imm: got %h/%h expected %h/%h", ex_pc, ex_imm, mon_e.pc, mon_e.imm);
            end
            if (ex_ctrl !== mon_e.ctrl || ex_rd !== mon_e.rd) begin
                n_err++; $display("FAIL sb_ctrl_rd: got %h/%h expected %h/%h", ex_ctrl, ex_rd, mon_e.ctrl, mon_e.rd);
            end
            if (ex_rs_addr !== mon_e.rs_addr) begin
                n_err++; $display("FAIL sb_rs_addr: got %h expected %h", ex_rs_addr, mon_e.rs_addr);
            end
            if (ex_rs_data !== mon_e.rs_data) begin
                n_err++; $display("FAIL sb_rs_data: got %h expected %h", ex_rs_data, mon_e.rs_data);
            end
            if (ex_fwd_src !== mon_e.fwd_src) begin
                n_err++; $display("FAIL sb_fwd_src: got %b expected %b", ex_fwd_src, mon_e.fwd_src);
            end
        end
    end

    task automatic test_reset();
        id_valid = 1'b1; id_pc = $urandom; id_imm = $urandom; id_ctrl = 16'hBEEF;
        id_rd = 6'd7; id_rs_addr = {6'd3, 6'd2, 6'd1};
        id_rs_data = {32'h3, 32'h2, 32'h1}; stall = 1'($urandom); flush = 1'b0;
        mem_fwd_en = 1'b1; mem_fwd_rd = 6'd1; mem_fwd_data = $urandom;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({ex_valid, ex_pc, ex_imm, ex_ctrl, ex_rd, ex_rs_addr, ex_rs_data, ex_fwd_src} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got valid=%0b pc=%h ctrl=%h rd=%h src=%b expected all zero",
                     ex_valid, ex_pc, ex_ctrl, ex_rd, ex_fwd_src);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model = '0;
        idle_inputs();
        id_valid = 1'b1; id_pc = 32'h100;
        tick();
        n_vec++;
        if (ex_valid !== 1'b1 || ex_pc !== 32'h100) begin
            n_err++; $display("FAIL reset_first_load: got valid=%0b pc=%h expected 1/00000100", ex_valid, ex_pc);
        end
    endtask

    task automatic test_priority();
        idle_inputs();
        id_valid = 1'b1; id_pc = 32'h140;
        id_rs_addr = {6'd5, 6'd5, 6'd5};
        id_rs_data = {32'h1111, 32'h1111, 32'h1111};
        mem_fwd_en = 1'b1; mem_fwd_rd = 6'd5; mem_fwd_data = 32'hAAAA;
        wb_fwd_en  = 1'b1; wb_fwd_rd  = 6'd5; wb_fwd_data  = 32'hBBBB;
        tick();
        for (int i = 0; i < NUM_SRC; i++) begin
            n_vec++;
            if (ex_rs_data[i] !== 32'hAAAA || ex_fwd_src[i] !== 2'b10) begin
                n_err++; $display("FAIL prio_mem[%0d]: got %h/%b expected 0000aaaa/10", i, ex_rs_data[i], ex_fwd_src[i]);
            end
        end
        mem_fwd_en = 1'b0;
        tick();
        n_vec++;
        if (ex_rs_data[0] !== 32'hBBBB || ex_fwd_src[0] !== 2'b01) begin
            n_err++; $display("FAIL prio_wb: got %h/%b expected 0000bbbb/01", ex_rs_data[0], ex_fwd_src[0]);
        end
    endtask

    task automatic test_x0_separation();
        idle_inputs();
        id_valid = 1'b1;
        id_rs_addr = {6'd32, 6'd37, 6'd0};
        id_rs_data = {32'h3333, 32'h2222, 32'h1234};
        mem_fwd_en = 1'b1; mem_fwd_rd = 6'd0; mem_fwd_data = 32'hDEAD;
        wb_fwd_en  = 1'b1; wb_fwd_rd  = 6'd5; wb_fwd_data  = 32'hCAFE;
        tick();
        n_vec++;
        if (ex_rs_data[0] !== 32'h1234 || ex_fwd_src[0] !== 2'b00) begin
            n_err++; $display("FAIL x0_no_fwd: got %h/%b expected 00001234/00", ex_rs_data[0], ex_fwd_src[0]);
        end
        n_vec++;
        if (ex_rs_data[1] !== 32'h2222 || ex_fwd_src[1] !== 2'b00) begin
            n_err++; $display("FAIL float_no_alias: got %h/%b expected 00002222/00", ex_rs_data[1], ex_fwd_src[1]);
        end
        mem_fwd_en = 1'b0;
        wb_fwd_rd = 6'd32;
        tick();
        n_vec++;
        if (ex_rs_data[2] !== 32'hCAFE || ex_fwd_src[2] !== 2'b01) begin
            n_err++; $display("FAIL f0_fwd: got %h/%b expected 0000cafe/01", ex_rs_data[2], ex_fwd_src[2]);
        end
    endtask

    task automatic test_stall_refresh();
        idle_inputs();
        id_valid = 1'b1; id_pc = 32'h200; id_imm = 32'hFFFF_FFF0; id_ctrl = 16'h1234; id_rd = 6'd11;
        id_rs_addr = {6'd4, 6'd9, 6'd3};
        id_rs_data = {32'h44, 32'h10, 32'h33};
        tick();
        stall = 1'b1;
        id_pc = 32'h999; id_ctrl = 16'hFFFF; id_rs_data = '1;
        tick();
        n_vec++;
        if (ex_rs_data[1] !== 32'h10 || ex_fwd_src[1] !== 2'b00 || ex_pc !== 32'h200) begin
            n_err++; $display("FAIL stall_hold: got %h/%b pc=%h expected 00000010/00 pc=00000200", ex_rs_data[1], ex_fwd_src[1], ex_pc);
        end
        wb_fwd_en = 1'b1; wb_fwd_rd = 6'd9; wb_fwd_data = 32'h20;
        mem_fwd_en = 1'b1; mem_fwd_rd = 6'd4; mem_fwd_data = 32'h99;
        tick();
        n_vec++;
        if (ex_rs_data[1] !== 32'h20 || ex_fwd_src[1] !== 2'b11) begin
            n_err++; $display("FAIL stall_refresh: got %h/%b expected 00000020/11", ex_rs_data[1], ex_fwd_src[1]);
        end
        n_vec++;
        if (ex_rs_data[2] !== 32'h44 || ex_fwd_src[2] !== 2'b00) begin
            n_err++; $display("FAIL stall_mem_ignored: got %h/%b expected 00000044/00", ex_rs_data[2], ex_fwd_src[2]);
        end
        wb_fwd_en = 1'b0; mem_fwd_en = 1'b0;
        tick();
        n_vec++;
        if (ex_rs_data[1] !== 32'h20 || ex_ctrl !== 16'h1234 || ex_rd !== 6'd11 || ex_valid !== 1'b1) begin
            n_err++; $display("FAIL stall_keep: got %h ctrl=%h rd=%h v=%0b expected 00000020 ctrl=1234 rd=0b v=1",
                              ex_rs_data[1], ex_ctrl, ex_rd, ex_valid);
        end
        stall = 1'b0;
    endtask

    task automatic test_flush_stall();
        idle_inputs();
        id_valid = 1'b1; id_pc = 32'h300; id_ctrl = 16'hA5A5; id_rd = 6'd40;
        tick();
        stall = 1'b1;
        tick();
        flush = 1'b1;
        tick();
        n_vec++;
        if (ex_valid !== 1'b0 || ex_ctrl !== '0 || ex_rd !== '0 || ex_pc !== 32'h300) begin
            n_err++; $display("FAIL flush_stall: got v=%0b ctrl=%h rd=%h pc=%h expected 0/0000/00/00000300",
                              ex_valid, ex_ctrl, ex_rd, ex_pc);
        end
        flush = 1'b0;
        tick();
        n_vec++;
        if (ex_valid !== 1'b0) begin
            n_err++; $display("FAIL bubble_held: got v=%0b expected 0", ex_valid);
        end
        stall = 1'b0;
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        for (int k = 0; k < 8; k++) begin
            id_valid = 1'b1; id_pc = 32'h1000 + 32'(4 * k); id_imm = $urandom;
            id_ctrl = 16'($urandom); id_rd = 6'($urandom);
            tick();
            n_vec++;
            if (ex_pc !== 32'h1000 + 32'(4 * k) || ex_valid !== 1'b1) begin
                n_err++; $display("FAIL b2b[%0d]: got pc=%h v=%0b expected %h/1", k, ex_pc, ex_valid, 32'h1000 + 32'(4 * k));
            end
        end
    endtask

    task automatic test_random();
        logic [REG_AW-1:0] pool [5];
        pool = '{6'd0, 6'd5, 6'd9, 6'd32, 6'd37};
        for (int k = 0; k < 200; k++) begin
            id_valid = 1'($urandom); id_pc = $urandom; id_imm = $urandom;
            id_ctrl = 16'($urandom); id_rd = pool[$urandom_range(4)];
            for (int i = 0; i < NUM_SRC; i++) begin
                id_rs_addr[i] = pool[$urandom_range(4)];
                id_rs_data[i] = $urandom;
            end
            stall = ($urandom_range(3) == 0);
            flush = ($urandom_range(7) == 0);
            mem_fwd_en = 1'($urandom); mem_fwd_rd = pool[$urandom_range(4)]; mem_fwd_data = $urandom;
            wb_fwd_en  = 1'($urandom); wb_fwd_rd  = pool[$urandom_range(4)]; wb_fwd_data  = $urandom;
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_stall();
        idle_inputs();
        id_valid = 1'b1; id_pc = 32'h400; id_ctrl = 16'h0F0F; id_rd = 6'd3;
        tick();
        stall = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        model = '0;
        n_vec++;
        if (ex_valid !== 1'b0 || ex_pc !== '0 || ex_ctrl !== '0) begin
            n_err++; $display("FAIL async_reset_mid_stall: got v=%0b pc=%h ctrl=%h expected 0/0/0", ex_valid, ex_pc, ex_ctrl);
        end
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_priority();
        test_x0_separation();
        test_stall_refresh();
        test_flush_stall();
        test_back_to_back();
        test_random();
        test_reset_mid_stall();
        @(posedge clk);
        #2;
        if (sb_q.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL sb_drain: got %0d entries left expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
